// File: rtl/param_seq_detector.sv
// Moore detector for an N-bit serial pattern (MSB first) with a saturating match counter.
// y is registered, one cycle after the final bit; `define PARAM_SEQ_DET_STICKY_EN adds a sticky 'seen' output.
module param_seq_detector #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
`ifdef PARAM_SEQ_DET_STICKY_EN
    ,
    output logic             seen
`endif
);

    localparam int               SW       = $clog2(N + 1);
    localparam int               N_ENC    = 2 ** SW;
    localparam int               TBL_W    = 2 * N_ENC * SW;
    localparam logic [SW-1:0]    S_DET    = SW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("param_seq_detector: N=%0d outside legal range 2..16", N);
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $error("param_seq_detector: CNT_W=%0d outside legal range 1..16", CNT_W);
    end

    // Full next-state table, entry (s*2+bit). Unused encodings above N fall back to 0.
    function automatic logic [TBL_W-1:0] build_tbl();
        logic [TBL_W-1:0] t;
        int               best;
        int               j;
        logic             ok;
        logic             sb;
        logic             bb;
        t = '0;
        for (int s = 0; s < N_ENC; s++) begin
            for (int b = 0; b < 2; b++) begin
                bb   = (b != 0);
                best = 0;
                if (s > N) begin
                    best = 0;
                end else if (s == N && OVERLAP == 0) begin
                    best = (bb == PATTERN[N-1]) ? 1 : 0;
                end else begin
                    // Longest pattern prefix that is a suffix of (matched prefix, bit).
                    for (int k = 1; k <= N; k++) begin
                        if (k <= s + 1) begin
                            ok = 1'b1;
                            for (int i = 0; i < k; i++) begin
                                j  = s + 1 - k + i;
                                sb = (j < s) ? PATTERN[N-1-j] : bb;
                                if (PATTERN[N-1-i] != sb) ok = 1'b0;
                            end
                            if (ok) best = k;
                        end
                    end
                end
                t[(s*2+b)*SW +: SW] = SW'(best);
            end
        end
        return t;
    endfunction

    localparam logic [TBL_W-1:0] NEXT_TBL = build_tbl();

    logic [SW-1:0]    state_q;
    logic [SW-1:0]    state_d;
    logic [SW-1:0]    next_s;
    logic [CNT_W-1:0] cnt_d;
    logic             enter;

    assign next_s = NEXT_TBL[int'({state_q, x}) * SW +: SW];

    always_comb begin
        state_d = state_q;
        if (en) state_d = next_s;
    end

    assign enter = en && (state_d == S_DET);

    always_comb begin
        cnt_d = match_cnt;
        if (en && clr_cnt) begin
            cnt_d = enter ? CNT_ONE : '0;
        end else if (enter && match_cnt != CNT_MAX) begin
            cnt_d = match_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= '0;
            y         <= 1'b0;
            match_cnt <= '0;
        end else begin
            state_q   <= state_d;
            y         <= (state_d == S_DET);
            match_cnt <= cnt_d;
        end
    end

`ifdef PARAM_SEQ_DET_STICKY_EN
    // A detection on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seen <= 1'b0;
        end else if (enter) begin
            seen <= 1'b1;
        end else if (en && clr_cnt) begin
            seen <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench for param_seq_detector: three configurations share one stimulus stream and
// are checked against a sliding-window reference model.
module tb_param_seq_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       y0, y1, y2;
    logic [7:0] c0;
    logic [1:0] c1;
    logic [2:0] c2;
`ifdef PARAM_SEQ_DET_STICKY_EN
    logic       s0, s1, s2;
`endif

    param_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y0), .match_cnt(c0)
`ifdef PARAM_SEQ_DET_STICKY_EN
        , .seen(s0)
`endif
    );

    param_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y1), .match_cnt(c1)
`ifdef PARAM_SEQ_DET_STICKY_EN
        , .seen(s1)
`endif
    );

    param_seq_detector #(.N(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(3)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y2), .match_cnt(c2)
`ifdef PARAM_SEQ_DET_STICKY_EN
        , .seen(s2)
`endif
    );

    localparam int          M_N   [3] = '{4, 4, 3};
    localparam logic [15:0] M_PAT [3] = '{16'hB, 16'hB, 16'h7};
    localparam int          M_OV  [3] = '{1, 0, 1};
    localparam int          M_MAX [3] = '{255, 3, 7};

    typedef struct packed {
        logic [2:0]  y;
        logic [2:0]  seen;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [15:0] c2;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hist [3];
    int          nbits[3];
    int          mcnt [3];
    logic        my   [3];
    logic        mseen[3];
    int          n_cmp = 0;
    int          n_err = 0;
    string       phase = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, want, $time);
        end
    endtask

    // Reference: detect when the last N sampled bits equal the pattern; without overlap,
    // only bits sampled after the previous detection may take part.
    task automatic model_step(input logic r, input logic e, input logic xx, input logic c);
        exp_t        ex;
        logic [15:0] mask;
        logic        det;
        for (int m = 0; m < 3; m++) begin
            if (!r) begin
                hist[m] = '0; nbits[m] = 0; mcnt[m] = 0; my[m] = 1'b0; mseen[m] = 1'b0;
            end else if (e) begin
                mask     = 16'((32'd1 << M_N[m]) - 1);
                hist[m]  = {hist[m][14:0], xx};
                nbits[m] = nbits[m] + 1;
                det      = (nbits[m] >= M_N[m]) && ((hist[m] & mask) == M_PAT[m]);
                my[m]    = det;
                if (det && M_OV[m] == 0) nbits[m] = 0;
                if (c) mcnt[m] = det ? 1 : 0;
                else if (det && mcnt[m] < M_MAX[m]) mcnt[m] = mcnt[m] + 1;
                if (det) mseen[m] = 1'b1;
                else if (c) mseen[m] = 1'b0;
            end
        end
        ex.y    = {my[2], my[1], my[0]};
        ex.seen = {mseen[2], mseen[1], mseen[0]};
        ex.c0   = 16'(mcnt[0]);
        ex.c1   = 16'(mcnt[1]);
        ex.c2   = 16'(mcnt[2]);
        exp_q.push_back(ex);
    endtask

    task automatic cyc(input logic r, input logic e, input logic xx, input logic c);
        exp_t ex;
        reset = r; en = e; x = xx; clr_cnt = c;
        model_step(r, e, xx, c);
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        check("y0",  32'(y0), 32'(ex.y[0]));
        check("y1",  32'(y1), 32'(ex.y[1]));
        check("y2",  32'(y2), 32'(ex.y[2]));
        check("cnt0", 32'(c0), 32'(ex.c0));
        check("cnt1", 32'(c1), 32'(ex.c1));
        check("cnt2", 32'(c2), 32'(ex.c2));
`ifdef PARAM_SEQ_DET_STICKY_EN
        check("seen0", 32'(s0), 32'(ex.seen[0]));
        check("seen1", 32'(s1), 32'(ex.seen[1]));
        check("seen2", 32'(s2), 32'(ex.seen[2]));
`endif
    endtask

    task automatic send(input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) cyc(1'b1, 1'b1, bits[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        phase = "reset";     cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("reset_y0", 32'(y0), 32'd0);
        check("reset_cnt0", 32'(c0), 32'd0);

        phase = "basic";     send(16'b1011, 4);
        check("basic_cnt0", 32'(c0), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);

        phase = "overlap";   cyc(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'b1011011, 7);
        check("ovl_cnt0", 32'(c0), 32'd2);
        check("novl_cnt1", 32'(c1), 32'd1);

        phase = "en_gap";    cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b011, 3);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("gap_hold_y0", 32'(y0), 32'd1);

        phase = "saturate";  cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) send(16'b1011, 4);
        check("sat_cnt1", 32'(c1), 32'd3);

        phase = "clr";       cyc(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'b10111011, 8);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        send(16'b101, 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_det_cnt0", 32'(c0), 32'd1);

        phase = "ones";      cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) cyc(1'b1, 1'b1, 1'b1, 1'b0);

        phase = "midreset";  cyc(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'b101, 3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        send(16'b1011, 4);
        send(16'b00, 2);

        phase = "random";    cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 60) != 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end

        phase = "end";
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
